// File: rtl/ivector_rr_queue.sv
// Bank of NCHAN independent FIFOs sharing one output port.
// A round-robin arbiter drains one word per cycle from the non-empty channels.
module ivector_rr_queue #(
    parameter  int WIDTH = 32,
    parameter  int NCHAN = 10,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(NCHAN),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_ena,
    input  logic [CW-1:0]    in_chan,
    input  logic [WIDTH-1:0] in_data,
    output logic [NCHAN-1:0] in_rdy,
    input  logic             out_rdy,
    output logic             out_ena,
    output logic [CW-1:0]    out_chan,
    output logic [WIDTH-1:0] out_data,
    output logic [NCHAN-1:0] nonempty,
    output logic [15:0]      drop_cnt
);

    logic [WIDTH-1:0] mem    [NCHAN][DEPTH];
    logic [PW-1:0]    rd_ptr [NCHAN];
    logic [PW-1:0]    wr_ptr [NCHAN];
    logic [PW:0]      count  [NCHAN];
    logic [CW-1:0]    rr_ptr;

    logic [NCHAN-1:0] enq_sel;
    logic [NCHAN-1:0] deq_sel;
    logic             enq_any;
    logic             grant_found;
    logic [CW-1:0]    grant_chan;
    logic [CW:0]      search_idx;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_rdy   = '0;
        nonempty = '0;
        for (int c = 0; c < NCHAN; c++) begin
            in_rdy[c]   = count[c] < (PW+1)'(DEPTH);
            nonempty[c] = count[c] != '0;
        end
    end

    // An out-of-range in_chan matches no channel, so it falls through to a drop.
    always_comb begin
        enq_sel = '0;
        for (int c = 0; c < NCHAN; c++) begin
            enq_sel[c] = in_ena && (in_chan == CW'(c)) && in_rdy[c];
        end
    end

    assign enq_any = |enq_sel;

    // Search rr_ptr+1 .. rr_ptr+NCHAN modulo NCHAN; first non-empty channel wins.
    always_comb begin
        grant_found = 1'b0;
        grant_chan  = '0;
        search_idx  = '0;
        for (int i = 1; i <= NCHAN; i++) begin
            search_idx = {1'b0, rr_ptr} + (CW+1)'(i);
            if (search_idx >= (CW+1)'(NCHAN)) begin
                search_idx = search_idx - (CW+1)'(NCHAN);
            end
            if (!grant_found && nonempty[search_idx[CW-1:0]]) begin
                grant_found = 1'b1;
                grant_chan  = search_idx[CW-1:0];
            end
        end
    end

    assign out_ena  = out_rdy && grant_found;
    assign out_chan = grant_chan;

    always_comb begin
        out_data = '0;
        deq_sel  = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (grant_found && (grant_chan == CW'(c))) begin
                out_data   = mem[c][rd_ptr[c]];
                deq_sel[c] = out_ena;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is sampled only on the clock edge.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int c = 0; c < NCHAN; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                count[c]  <= '0;
            end
            rr_ptr   <= CW'(NCHAN - 1);
            drop_cnt <= '0;
        end else begin
            for (int c = 0; c < NCHAN; c++) begin
                if (enq_sel[c]) begin
                    wr_ptr[c] <= wr_ptr[c] + PW'(1);
                end
                if (deq_sel[c]) begin
                    rd_ptr[c] <= rd_ptr[c] + PW'(1);
                end
                case ({enq_sel[c], deq_sel[c]})
                    2'b10:   count[c] <= count[c] + (PW+1)'(1);
                    2'b01:   count[c] <= count[c] - (PW+1)'(1);
                    default: count[c] <= count[c];
                endcase
            end
            if (out_ena) begin
                rr_ptr <= grant_chan;
            end
            if (in_ena && !enq_any && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // NOTE: the buffer array has no reset; stale words are unreachable once pointers and counts clear.
    always_ff @(posedge CLK) begin
        for (int c = 0; c < NCHAN; c++) begin
            if (enq_sel[c]) begin
                mem[c][wr_ptr[c]] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_ivector_rr_queue.sv
// Self-checking bench for ivector_rr_queue: per-channel scoreboard queues,
// an arbitration vector table and directed multi-cycle sequences.
module tb_ivector_rr_queue;

    localparam int WIDTH = 32;
    localparam int NCHAN = 10;
    localparam int DEPTH = 4;
    localparam int CW    = 4;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             in_ena;
    logic [CW-1:0]    in_chan;
    logic [WIDTH-1:0] in_data;
    logic [NCHAN-1:0] in_rdy;
    logic             out_rdy;
    logic             out_ena;
    logic [CW-1:0]    out_chan;
    logic [WIDTH-1:0] out_data;
    logic [NCHAN-1:0] nonempty;
    logic [15:0]      drop_cnt;

    ivector_rr_queue #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .in_ena   (in_ena),
        .in_chan  (in_chan),
        .in_data  (in_data),
        .in_rdy   (in_rdy),
        .out_rdy  (out_rdy),
        .out_ena  (out_ena),
        .out_chan (out_chan),
        .out_data (out_data),
        .nonempty (nonempty),
        .drop_cnt (drop_cnt)
    );

    always #5 CLK = ~CLK;

    typedef logic [WIDTH-1:0] word_q_t[$];
    word_q_t mq [NCHAN];
    int      exp_drop = 0;
    int      total = 0;
    int      bad = 0;

    typedef struct {
        logic          rdy;
        logic          ena;
        logic [CW-1:0] chan;
    } arb_vec_t;

    typedef struct {
        logic [CW-1:0] chan;
        logic [15:0]   drops;
    } drop_vec_t;

    arb_vec_t  av [11];
    drop_vec_t dv [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NCHAN-1:0] m_nonempty();
        logic [NCHAN-1:0] r;
        r = '0;
        for (int c = 0; c < NCHAN; c++) r[c] = (mq[c].size() != 0);
        return r;
    endfunction

    function automatic logic [NCHAN-1:0] m_rdy();
        logic [NCHAN-1:0] r;
        r = '0;
        for (int c = 0; c < NCHAN; c++) r[c] = (mq[c].size() < DEPTH);
        return r;
    endfunction

    // One clock cycle: compare against the model, update the scoreboard, advance.
    task automatic step();
        logic acc;
        #1;
        check("nonempty", nonempty, m_nonempty());
        check("in_rdy", in_rdy, m_rdy());
        check("drop_cnt", drop_cnt, exp_drop);
        check("out_ena", out_ena, out_rdy && (m_nonempty() != '0));
        if (m_nonempty() == '0) begin
            check("idle_chan", out_chan, 0);
            check("idle_data", out_data, 0);
        end
        acc = 1'b0;
        if (in_ena) begin
            if (int'(in_chan) < NCHAN && mq[in_chan].size() < DEPTH) acc = 1'b1;
            else if (exp_drop < 65535) exp_drop++;
        end
        if (out_ena) begin
            if (int'(out_chan) >= NCHAN || mq[out_chan].size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_word: got chan=%0d want a channel holding data", out_chan);
            end else begin
                check("out_data", out_data, mq[out_chan].pop_front());
            end
        end
        if (acc) mq[in_chan].push_back(in_data);
        @(posedge CLK);
        #1;
    endtask

    task automatic enq(input logic [CW-1:0] ch, input logic [WIDTH-1:0] d);
        in_ena  = 1'b1;
        in_chan = ch;
        in_data = d;
        step();
        in_ena  = 1'b0;
    endtask

    task automatic do_reset();
        nRST    = 1'b0;
        in_ena  = 1'b0;
        out_rdy = 1'b0;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        for (int c = 0; c < NCHAN; c++) mq[c].delete();
        exp_drop = 0;
    endtask

    task automatic drain();
        int n;
        n       = 0;
        out_rdy = 1'b1;
        in_ena  = 1'b0;
        while (m_nonempty() != '0 && n < 64) begin
            step();
            n++;
        end
        #1;
        check("drain_done", nonempty, 0);
        out_rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        av[0]  = '{1'b1, 1'b1, 4'd0};
        av[1]  = '{1'b1, 1'b1, 4'd2};
        av[2]  = '{1'b0, 1'b0, 4'd7};
        av[3]  = '{1'b1, 1'b1, 4'd7};
        av[4]  = '{1'b1, 1'b1, 4'd0};
        av[5]  = '{1'b1, 1'b1, 4'd2};
        av[6]  = '{1'b1, 1'b1, 4'd7};
        av[7]  = '{1'b1, 1'b1, 4'd0};
        av[8]  = '{1'b1, 1'b1, 4'd2};
        av[9]  = '{1'b1, 1'b1, 4'd7};
        av[10] = '{1'b1, 1'b0, 4'd0};
        dv[0]  = '{4'd10, 16'd1};
        dv[1]  = '{4'd15, 16'd2};
        dv[2]  = '{4'd4,  16'd3};

        in_chan = '0;
        in_data = '0;
        do_reset();

        // Reset state, with out_rdy high so out_ena=0 is meaningful.
        out_rdy = 1'b1;
        #1;
        check("rst_in_rdy", in_rdy, 10'h3FF);
        check("rst_nonempty", nonempty, 0);
        check("rst_out_ena", out_ena, 0);
        check("rst_out_chan", out_chan, 0);
        check("rst_out_data", out_data, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        step();

        // Single word on channel 3, then consumed the cycle out_rdy rises.
        out_rdy = 1'b0;
        enq(4'd3, 32'hA5);
        #1;
        check("t1_nonempty", nonempty, 10'h008);
        out_rdy = 1'b1;
        #1;
        check("t1_ena", out_ena, 1);
        check("t1_chan", out_chan, 3);
        check("t1_data", out_data, 32'hA5);
        step();
        check("t1_empty", nonempty, 0);
        out_rdy = 1'b0;

        // Fill channel 0, overflow once, drain in order.
        for (int i = 1; i <= 4; i++) enq(4'd0, WIDTH'(i));
        #1;
        check("t2_full", in_rdy[0], 0);
        enq(4'd0, 32'd5);
        #1;
        check("t2_drop", drop_cnt, 1);
        out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("t2_chan", out_chan, 0);
            check("t2_data", out_data, i);
            step();
        end
        out_rdy = 1'b0;

        // Round-robin fairness from a fresh reset.
        do_reset();
        for (int w = 0; w < 3; w++) begin
            enq(4'd0, 32'h000 + WIDTH'(w));
            enq(4'd2, 32'h200 + WIDTH'(w));
            enq(4'd7, 32'h700 + WIDTH'(w));
        end
        for (int i = 0; i < 11; i++) begin
            out_rdy = av[i].rdy;
            #1;
            check("t3_ena", out_ena, av[i].ena);
            check("t3_chan", out_chan, av[i].chan);
            step();
        end
        out_rdy = 1'b0;

        // Simultaneous enqueue/dequeue on channel 5 across pointer wrap.
        enq(4'd5, 32'h50);
        enq(4'd5, 32'h51);
        for (int i = 0; i < 6; i++) begin
            in_ena  = 1'b1;
            in_chan = 4'd5;
            in_data = 32'h52 + WIDTH'(i);
            out_rdy = 1'b1;
            #1;
            check("t4_chan", out_chan, 5);
            check("t4_data", out_data, 32'h50 + i);
            step();
        end
        in_ena = 1'b0;
        #1;
        check("t4_rdy", in_rdy[5], 1);
        check("t4_nonempty", nonempty, 10'h020);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t4_tail", out_data, 32'h56 + i);
            step();
        end
        out_rdy = 1'b0;
        #1;
        check("t4_empty", nonempty, 0);

        // Out-of-range channels and a full channel are dropped without side effects.
        enq(4'd1, 32'h11);
        for (int i = 0; i < 4; i++) enq(4'd4, 32'h40 + WIDTH'(i));
        for (int i = 0; i < 3; i++) begin
            enq(dv[i].chan, 32'hDEAD);
            #1;
            check("t5_drop", drop_cnt, dv[i].drops);
            check("t5_rdy", in_rdy, 10'h3EF);
            check("t5_nonempty", nonempty, 10'h012);
        end
        drain();

        // Reset mid-drain, then arbitration restarts at channel 0.
        for (int w = 0; w < 2; w++) begin
            enq(4'd1, 32'h100 + WIDTH'(w));
            enq(4'd3, 32'h300 + WIDTH'(w));
            enq(4'd6, 32'h600 + WIDTH'(w));
        end
        out_rdy = 1'b1;
        step();
        step();
        do_reset();
        out_rdy = 1'b1;
        #1;
        check("t6_rdy", in_rdy, 10'h3FF);
        check("t6_nonempty", nonempty, 0);
        check("t6_ena", out_ena, 0);
        check("t6_chan", out_chan, 0);
        check("t6_data", out_data, 0);
        check("t6_drop", drop_cnt, 0);
        out_rdy = 1'b0;
        enq(4'd4, 32'h44);
        enq(4'd0, 32'h0A);
        out_rdy = 1'b1;
        #1;
        check("t6_first", out_chan, 0);
        step();
        check("t6_second", out_chan, 4);
        step();
        out_rdy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
